// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_port_arbiter
//  Purpose  : Shares the register-file write port between pipeline writeback
//             (always first) and a FIFO of buffered multiply/divide results.
//  Revision : 1.0
// ============================================================================
module wb_port_arbiter #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_we,
  input  logic [4:0]               wb_rd,
  input  logic [WIDTH-1:0]         wb_data,
  input  logic                     mdu_valid,
  input  logic [4:0]               mdu_rd,
  input  logic [WIDTH-1:0]         mdu_data,
  output logic                     mdu_ready,
  output logic                     rf_we,
  output logic [4:0]               rf_waddr,
  output logic [WIDTH-1:0]         rf_wdata,
  output logic                     stall_req,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] c_depth = CW'(DEPTH);
  localparam logic [SW-1:0] c_limit = SW'(STARVE_LIMIT);

  typedef enum logic [0:0] {
    NORMAL = 1'b0,
    STALL  = 1'b1
  } state_t;

  state_t r_state, w_state_next;

  logic [WIDTH+4:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic [SW-1:0]    r_starve;

  logic             w_push, w_pop, w_empty;
  logic [4:0]       w_head_rd;
  logic [WIDTH-1:0] w_head_data;

  assign w_empty     = (r_count == '0);
  assign mdu_ready   = (r_count < c_depth);
  assign w_push      = mdu_valid && mdu_ready;
  // Pop is decided on the pre-edge count, so an entry pushed into an empty
  // FIFO can only retire on the following cycle.
  assign w_pop       = !wb_we && !w_empty;
  assign w_head_rd   = r_mem[r_rptr][WIDTH+4:WIDTH];
  assign w_head_data = r_mem[r_rptr][WIDTH-1:0];
  assign fifo_count  = r_count;
  assign stall_req   = (r_state == STALL);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {mdu_rd, mdu_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= '0;
    end else if (w_empty || w_pop) begin
      r_starve <= '0;
    end else if (wb_we && (r_starve != c_limit)) begin
      r_starve <= r_starve + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (wb_we) begin
      rf_we    <= (wb_rd != 5'd0);
      rf_waddr <= wb_rd;
      rf_wdata <= wb_data;
    end else if (w_pop) begin
      rf_we    <= (w_head_rd != 5'd0);
      rf_waddr <= w_head_rd;
      rf_wdata <= w_head_data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= NORMAL;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      NORMAL: if (r_starve == c_limit) w_state_next = STALL;
      // A late push while empty keeps the freeze until that entry drains too.
      STALL:  if (w_empty && !w_push) w_state_next = NORMAL;
      default: w_state_next = NORMAL;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_port_arbiter
//  Purpose  : Directed bench for wb_port_arbiter with hand-computed results.
//  Revision : 1.0
// ============================================================================
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall_req;
  logic [1:0]  fifo_count;

  int errors = 0;
  int checks = 0;

  wb_port_arbiter #(.WIDTH(32), .DEPTH(2), .STARVE_LIMIT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .mdu_valid  (mdu_valid),
    .mdu_rd     (mdu_rd),
    .mdu_data   (mdu_data),
    .mdu_ready  (mdu_ready),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .stall_req  (stall_req),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    mdu_valid = 1'b0; mdu_rd = '0; mdu_data = '0;
    step(); step();
    rst = 1'b0;
    check("rst_rf_we",    32'(rf_we),      32'd0);
    check("rst_waddr",    32'(rf_waddr),   32'd0);
    check("rst_wdata",    rf_wdata,        32'd0);
    check("rst_stall",    32'(stall_req),  32'd0);
    check("rst_count",    32'(fifo_count), 32'd0);
    check("rst_ready",    32'(mdu_ready),  32'd1);

    // Single pipeline write
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    step();
    wb_we = 1'b0;
    check("wb_we",        32'(rf_we),      32'd1);
    check("wb_addr",      32'(rf_waddr),   32'd5);
    check("wb_data",      rf_wdata,        32'hDEADBEEF);
    step();
    check("wb_idle_we",   32'(rf_we),      32'd0);
    check("wb_hold_addr", 32'(rf_waddr),   32'd5);
    check("wb_hold_data", rf_wdata,        32'hDEADBEEF);

    // MDU push then retire on an idle cycle
    mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'h12345678;
    step();
    mdu_valid = 1'b0;
    check("mdu_cnt1",     32'(fifo_count), 32'd1);
    check("mdu_push_we",  32'(rf_we),      32'd0);
    step();
    check("mdu_pop_we",   32'(rf_we),      32'd1);
    check("mdu_pop_addr", 32'(rf_waddr),   32'd7);
    check("mdu_pop_data", rf_wdata,        32'h12345678);
    check("mdu_cnt0",     32'(fifo_count), 32'd0);

    // rd=0 result is retired as a suppressed write
    mdu_valid = 1'b1; mdu_rd = 5'd0; mdu_data = 32'hAAAA5555;
    step();
    mdu_valid = 1'b0;
    check("r0_cnt1",      32'(fifo_count), 32'd1);
    step();
    check("r0_we",        32'(rf_we),      32'd0);
    check("r0_cnt0",      32'(fifo_count), 32'd0);

    // FIFO fill under pipeline pressure, then in-order drain
    wb_we = 1'b1; wb_rd = 5'd9; wb_data = 32'h99;
    mdu_valid = 1'b1; mdu_rd = 5'd1; mdu_data = 32'h11;
    step();
    check("fill_cnt1",    32'(fifo_count), 32'd1);
    check("fill_wb_addr", 32'(rf_waddr),   32'd9);
    check("fill_ready1",  32'(mdu_ready),  32'd1);
    mdu_rd = 5'd2; mdu_data = 32'h22;
    step();
    check("fill_cnt2",    32'(fifo_count), 32'd2);
    check("fill_ready0",  32'(mdu_ready),  32'd0);
    mdu_rd = 5'd3; mdu_data = 32'h33;
    step();
    check("full_hold",    32'(fifo_count), 32'd2);
    check("full_wb_we",   32'(rf_we),      32'd1);
    wb_we = 1'b0;
    step();
    check("drain1_addr",  32'(rf_waddr),   32'd1);
    check("drain1_data",  rf_wdata,        32'h11);
    check("drain1_cnt",   32'(fifo_count), 32'd1);
    step();
    // push of r3 and pop of r2 land on the same edge
    mdu_valid = 1'b0;
    check("drain2_addr",  32'(rf_waddr),   32'd2);
    check("drain2_data",  rf_wdata,        32'h22);
    check("pushpop_cnt",  32'(fifo_count), 32'd1);
    step();
    check("drain3_we",    32'(rf_we),      32'd1);
    check("drain3_addr",  32'(rf_waddr),   32'd3);
    check("drain3_data",  rf_wdata,        32'h33);
    check("drain3_cnt",   32'(fifo_count), 32'd0);
    check("drain_nostall",32'(stall_req),  32'd0);

    // Starvation: one entry waits behind continuous writeback
    wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'h44;
    mdu_valid = 1'b1; mdu_rd = 5'd6; mdu_data = 32'h66;
    step();
    mdu_valid = 1'b0;
    check("starve_cnt",   32'(fifo_count), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      step();
      check("starve_wait", 32'(stall_req), 32'd0);
    end
    step();
    check("stall_rise",   32'(stall_req),  32'd1);
    check("stall_cnt",    32'(fifo_count), 32'd1);
    check("stall_wb_pri", 32'(rf_waddr),   32'd4);
    wb_we = 1'b0;
    step();
    check("stall_ret_we", 32'(rf_we),      32'd1);
    check("stall_ret_ad", 32'(rf_waddr),   32'd6);
    check("stall_ret_dt", rf_wdata,        32'h66);
    check("stall_held",   32'(stall_req),  32'd1);
    step();
    check("stall_fall",   32'(stall_req),  32'd0);
    check("stall_idle",   32'(rf_we),      32'd0);

    // Reset while stalled with two buffered entries
    wb_we = 1'b1; wb_rd = 5'd8; wb_data = 32'h88;
    mdu_valid = 1'b1; mdu_rd = 5'd10; mdu_data = 32'hA;
    step();
    mdu_rd = 5'd11; mdu_data = 32'hB;
    step();
    mdu_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("rst_stall_pre",32'(stall_req),  32'd1);
    check("rst_cnt_pre",  32'(fifo_count), 32'd2);
    rst = 1'b1; wb_we = 1'b0;
    step();
    rst = 1'b0;
    check("mid_rst_cnt",  32'(fifo_count), 32'd0);
    check("mid_rst_stall",32'(stall_req),  32'd0);
    check("mid_rst_we",   32'(rf_we),      32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_we",  32'(rf_we),      32'd0);
      check("post_rst_cnt", 32'(fifo_count), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Shares the single register-file write port between the pipeline writeback path (stage-5 output) and a multi-cycle multiply/divide unit (MDU). Pipeline writeback always has priority and is never delayed. MDU results are buffered in a small FIFO and drained into idle write-port cycles. A starvation counter raises a pipeline stall request so that buffered MDU results are eventually retired.

Parameters:
Width, 32, data width of write-port and result data
Depth, 2, MDU result FIFO entries (power of two, ≥2)
StarveLimit, 8, cycles a FIFO head may wait before stall_req asserts (≥1)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
wb_we  input  1  pipeline writeback valid (stage-5 RegWrite)
wb_rd  input  5  pipeline destination register
wb_data  input  Width  pipeline writeback value
mdu_valid  input  1  MDU result offered
mdu_rd  input  5  MDU destination register
mdu_data  input  Width  MDU result value
mdu_ready  output  1  FIFO can accept this cycle
rf_we  output  1  register-file write enable (registered)
rf_waddr  output  5  register-file write address (registered)
rf_wdata  output  Width  register-file write data (registered)
stall_req  output  1  request pipeline freeze (registered)
fifo_count  output  log2(Depth)+1  current FIFO occupancy

Behaviour:
- One clock; reset is synchronous and active-high (rst sampled on rising clk). Reset: rf_we=0, rf_waddr=0, rf_wdata=0, stall_req=0, FIFO empty, fifo_count=0, starve counter=0, state=NORMAL. Reset mid-operation discards buffered MDU results.
- mdu_ready = (fifo_count < Depth) combinationally. MDU push occurs on an edge where mdu_valid && mdu_ready. mdu_valid with rd=0 is pushed normally and retired as a suppressed write.
- Port select, evaluated each cycle on pre-edge state:
  - wb_we=1: pipeline granted.
  - else FIFO non-empty: FIFO head granted and popped.
  - else: no write.
- Registered outputs, 1-cycle latency. The granted source's rd/data appear on rf_waddr/rf_wdata on the next edge. rf_we = granted && rd≠0. With no grant, rf_we=0 and rf_waddr/rf_wdata hold their previous values.
- Simultaneous push and pop on the same edge: both take effect, and count is unchanged. A push into an empty FIFO is not poppable in the same cycle; earliest retire is the next cycle.
- FIFO order is strictly in-order. Pointers wrap modulo Depth.
- Starve counter: it clears when the FIFO is empty or a pop occurs. It increments (saturating at StarveLimit) when the FIFO is non-empty and wb_we=1.
- State machine:
  - NORMAL→STALL when the counter reaches StarveLimit. stall_req=1 from the following edge.
  - STALL→NORMAL on the edge after the FIFO becomes empty. stall_req=0 from that edge.
  - In STALL, pipeline grants still take priority. The upstream freeze guarantees bubbles (wb_we=0), and each bubble pops one entry.
- MDU push is still accepted in STALL and extends the stall until the FIFO is empty.
- RAW ordering between MDU and pipeline writes to the same register is the issuing logic's responsibility. No address comparison is performed here.

Test Plan:
- Reset, then wb_we=1, wb_rd=5, wb_data=0xDEADBEEF for 1 cycle → the next cycle shows rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, and the cycle after shows rf_we=0.
- wb_we=0, MDU pushes rd=7/0x12345678 → one cycle later fifo_count=1, next cycle pop, and the following cycle rf_we=1, rf_waddr=7. Pushing rd=0 instead produces rf_we=0 and count returning to 0.
- wb_we held 1; MDU pushes rd=1, 2, 3 on consecutive cycles → mdu_ready=0 after 2 pushes (count=2), and the third is held by the MDU. Then drop wb_we → writes appear to r1 then r2, in order, on consecutive cycles.
- wb_we held 1 with 1 entry buffered → stall_req rises after StarveLimit=8 waiting cycles. Then drive wb_we=0 → entry retired and stall_req falls the edge after empty.
- Simultaneous push and pop with count=1 → count stays 1 and the data order is preserved. Assert rst mid-STALL with count=2 → the next cycle shows count=0, stall_req=0, rf_we=0, and no buffered write ever appears.
